// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with a TX shifter, an RX sampler with a
// one-byte holding register, and a STATUS register. Read data is registered.
`timescale 1ns/1ps
module uart_periph #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq,
  output logic       tx,
  input  logic       rx
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_s1_q, rx_s2_q;
  logic [7:0]    rx_hold_q, rx_hold_d;
  logic          rx_ready_q, rx_ready_d;
  logic          overrun_q, overrun_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    data_out_q, data_out_d;

  logic wr_data, rd_data, wr_stat, tx_ready, tx_bit_end, tx_accept;
  logic byte_done, frame_err;

  assign wr_data    = cs & we & (addr == 8'h00);
  assign rd_data    = cs & ~we & (addr == 8'h00);
  assign wr_stat    = cs & we & (addr == 8'h01);
  assign tx_ready   = (tx_state_q == TX_IDLE);
  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  // The last cycle of a stop bit also accepts a write so frames can run back to back.
  assign tx_accept  = wr_data & (tx_ready | ((tx_state_q == TX_STOP) & tx_bit_end));

  // TX next state: walk start, 8 data bits LSB first, stop; load on an accepted write.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
      end
      TX_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_bit_d   = 3'd0;
        tx_state_d = TX_DATA;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_STOP: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_accept) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_bit_d   = 3'd0;
      tx_shift_d = data_in;
      tx_d       = 1'b0;
    end
  end

  // RX next state: qualify the start bit at mid-bit, then sample each bit centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        if (rx_s2_q) begin
          byte_done  = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          frame_err  = 1'b1;
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Status flags, holding register and registered read mux; setting beats clearing.
  always_comb begin
    rx_hold_d  = byte_done ? rx_shift_q : rx_hold_q;
    rx_ready_d = byte_done ? 1'b1 : (rd_data ? 1'b0 : rx_ready_q);
    overrun_d  = (byte_done & rx_ready_q & ~rd_data) ? 1'b1 : (wr_stat ? 1'b0 : overrun_q);
    ferr_d     = frame_err ? 1'b1 : (wr_stat ? 1'b0 : ferr_q);
    data_out_d = data_out_q;
    if (cs && !we) begin
      case (addr)
        8'h00:   data_out_d = rx_hold_q;
        8'h01:   data_out_d = {4'b0000, ferr_q, overrun_q, rx_ready_q, tx_ready};
        default: data_out_d = 8'h00;
      endcase
    end
  end

  // Control state, synchronizer and read data with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_ready_q <= rx_ready_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      data_out_q <= data_out_d;
    end
  end

  // Shift and holding registers carry only data and need no reset.
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
    rx_hold_q  <= rx_hold_d;
  end

  assign data_out = data_out_q;
  assign irq      = rx_ready_q;
  assign tx       = tx_q;
endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed and randomized checks of uart_periph against a
// frame-level reference model of the register behaviour.
`timescale 1ns/1ps
module tb_uart_periph;
  localparam int C = 10;

  logic       clk, rst, cs, we, rx;
  logic [7:0] addr, data_in;
  logic [7:0] data_out;
  logic       irq, tx;

  int checks   = 0;
  int failures = 0;

  // Reference model of software-visible RX state.
  logic       m_rdy, m_ovr, m_ferr;
  logic [7:0] m_hold;

  uart_periph #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .irq(irq), .tx(tx), .rx(rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    d = data_out;
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0000, m_ferr, m_ovr, m_rdy, 1'b1};
  endfunction

  task automatic m_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      if (m_rdy) m_ovr = 1'b1;
      m_rdy  = 1'b1;
      m_hold = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic m_clear();
    m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Drive one serial frame on rx; the line is left at the stop-bit level.
  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (C) tick();
    end
  endtask

  // Start a TX frame and compare every cycle of the line against the frame bits.
  task automatic tx_frame_check(input logic [7:0] b);
    logic [9:0] f;
    logic [7:0] d;
    f = {1'b1, b, 1'b0};
    bus_write(8'h00, b);
    for (int k = 0; k < 100; k++) begin
      check("tx_bit", {7'd0, tx}, {7'd0, f[k / C]});
      if (k == 51 || k == 99) check("status_busy", data_out, 8'h00);
      cs = 1'b0; we = 1'b0;
      if (k == 30) begin
        cs = 1'b1; we = 1'b1; addr = 8'h00; data_in = ~b;
      end else if (k == 50 || k == 98) begin
        cs = 1'b1; we = 1'b0; addr = 8'h01;
      end
      tick();
    end
    cs = 1'b0; we = 1'b0;
    check("tx_idle", {7'd0, tx}, 8'h01);
    bus_read(8'h01, d);
    check("status_tx_done", d, m_status());
  endtask

  task automatic rx_good(input logic [7:0] b);
    rx_send(b, 1'b1);
    repeat (3) tick();
    m_frame(b, 1'b1);
  endtask

  initial begin
    logic [7:0] d, r;
    cs = 1'b0; we = 1'b0; addr = 8'h00; data_in = 8'h00; rx = 1'b1;
    rst = 1'b1;
    m_clear(); m_hold = 8'h00;
    repeat (3) tick();
    check("rst_tx", {7'd0, tx}, 8'h01);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    rst = 1'b0;
    tick();
    bus_read(8'h01, d);
    check("status_after_reset", d, 8'h01);
    bus_read(8'h05, d);
    check("unmapped_read", d, 8'h00);

    // Transmit: directed pattern then random bytes.
    tx_frame_check(8'hA5);
    for (int n = 0; n < 2; n++) tx_frame_check(8'($urandom));

    // Receive one byte and read it back.
    rx_good(8'h3C);
    check("irq_set", {7'd0, irq}, {7'd0, m_rdy});
    bus_read(8'h01, d);
    check("status_rx", d, m_status());
    bus_read(8'h00, d);
    check("rx_data", d, m_hold);
    m_rdy = 1'b0;
    check("irq_clear", {7'd0, irq}, 8'h00);
    bus_read(8'h01, d);
    check("status_after_read", d, m_status());

    // Random received bytes.
    for (int n = 0; n < 3; n++) begin
      r = 8'($urandom);
      rx_good(r);
      bus_read(8'h00, d);
      check("rx_rand", d, m_hold);
      m_rdy = 1'b0;
    end

    // Overrun.
    rx_good(8'h11);
    rx_good(8'h22);
    bus_read(8'h01, d);
    check("status_overrun", d, m_status());
    bus_read(8'h00, d);
    check("rx_overrun_data", d, m_hold);
    m_rdy = 1'b0;
    bus_write(8'h01, 8'h00);
    m_ovr = 1'b0; m_ferr = 1'b0;
    bus_read(8'h01, d);
    check("status_cleared", d, m_status());

    // Framing error with rx held low afterwards.
    r = 8'($urandom);
    rx_send(r, 1'b0);
    repeat (30) tick();
    rx = 1'b1;
    repeat (3) tick();
    m_frame(r, 1'b0);
    bus_read(8'h01, d);
    check("status_ferr", d, m_status());
    check("irq_ferr", {7'd0, irq}, 8'h00);
    rx_good(8'h55);
    bus_read(8'h00, d);
    check("rx_after_ferr", d, m_hold);
    m_rdy = 1'b0;
    bus_write(8'h01, 8'hFF);
    m_ovr = 1'b0; m_ferr = 1'b0;
    bus_read(8'h01, d);
    check("status_ferr_cleared", d, m_status());

    // Reset in the middle of both a TX and an RX frame.
    bus_write(8'h00, 8'h00);
    rx = 1'b0;
    repeat (40) tick();
    check("tx_low_mid_frame", {7'd0, tx}, 8'h00);
    rst = 1'b1;
    #1;
    check("tx_async_reset", {7'd0, tx}, 8'h01);
    rx = 1'b1;
    m_clear();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    bus_read(8'h01, d);
    check("status_after_midreset", d, m_status());
    repeat (150) tick();
    bus_read(8'h01, d);
    check("no_spurious_byte", d, m_status());

    // Short glitch on rx must not start a frame.
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (150) tick();
    bus_read(8'h01, d);
    check("glitch_ignored", d, m_status());
    check("glitch_irq", {7'd0, irq}, 8'h00);
    r = 8'($urandom);
    rx_good(r);
    bus_read(8'h00, d);
    check("rx_after_glitch", d, m_hold);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped 8N1 UART peripheral occupying the UART I/O page at 0xC000-0xC0FF. It consumes the UART chip select and the low address byte produced by the system address decoder, together with the CPU write strobe and data bus. It provides a transmit shifter, a receive sampler with a one-byte holding register, and a status register. Its registered read data feeds the CPU read-data mux.

## Interface
- CLK_FREQ, 25000000: system clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ / BAUD, integer division, must be ≥ 4.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  UART page select from the address decoder; one bus access per clk cycle while high.
- we  in  1  1 = write, 0 = read; qualified by cs.
- addr  in  8  register offset (CPU addr[7:0]).
- data_in  in  8  CPU write data.
- data_out  out  8  registered read data.
- irq  out  1  level interrupt; equals the rx_ready status bit.
- tx  out  1  serial output; idles high.
- rx  in  1  serial input; asynchronous to clk.

## Operation
- Register map, decoded on addr[7:0]:
  - 0x00 DATA. A write loads the TX shifter only when tx_ready=1; writes while busy are dropped. A read returns the RX holding register and clears rx_ready.
  - 0x01 STATUS. Read: bit0 tx_ready, bit1 rx_ready, bit2 overrun, bit3 framing_err, bits7:4 = 0. A write of any value clears overrun and framing_err.
  - 0x02-0xFF. Reads return 0x00; writes are ignored.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
- TX FSM:
  - States: IDLE → START → DATA → STOP → IDLE.
  - A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) advance the state.
  - tx_ready is 1 only in IDLE.
- RX path: rx passes through a 2-flop synchronizer; the FSM uses the second flop.
- RX FSM states:
  - IDLE: a low level moves to START.
  - START: wait CLKS_PER_BIT/2 cycles and resample. If low, go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample high: store the byte in the holding register and set rx_ready. If rx_ready was already 1, the new byte overwrites the old one and overrun is set.
    - Sample low: discard the byte, set framing_err, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized rx is high, then go to IDLE.
- Simultaneous events:
  - DATA read and byte completion in the same cycle: data_out returns the old byte, the new byte is stored, rx_ready stays 1, overrun is not set.
  - STATUS write and error detection in the same cycle: set wins.

## Timing
- Reset values: tx=1, data_out=0x00, irq=0, tx_ready=1, rx_ready=0, overrun=0, framing_err=0, both FSMs in IDLE, counters 0.
- Reset asserted mid-frame aborts both FSMs immediately. tx returns high asynchronously and any partial RX byte is lost.
- Read latency is 1 cycle: if cs & !we at edge N, data_out is valid after edge N and holds until the next read. Side effects (clearing rx_ready) also take effect at edge N.
- TX: a DATA write accepted at edge N drives tx low and tx_ready=0 from edge N. The frame lasts 10·CLKS_PER_BIT cycles, and tx_ready returns to 1 at edge N + 10·CLKS_PER_BIT. A new write accepted on that same edge starts back-to-back frames with no idle gap.
- RX: rx_ready asserts 2 sync cycles + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling start edge, ±1 cycle.
- irq follows rx_ready with no added delay.

## Test plan
All scenarios use CLK_FREQ=1000000 and BAUD=100000 (10 clocks per bit).
- Reset, then read STATUS → data_out=0x01; tx=1; irq=0.
- Write 0xA5 to DATA → tx shows 0,1,0,1,0,0,1,0,1,1, 10 cycles each. STATUS reads 0x00 during the frame and 0x01 exactly 100 cycles after the write. A second write during the frame is dropped and does not alter the waveform.
- Drive an rx frame carrying 0x3C → irq=1 and STATUS=0x03. A DATA read returns 0x3C, irq=0 on the next cycle, and STATUS=0x01.
- Send 0x11 then 0x22 without reading → STATUS=0x07 and a DATA read returns 0x22. A write of 0x00 to STATUS is followed by a STATUS read of 0x01.
- Drive a frame with stop bit=0 and hold rx low for 30 cycles, then high → STATUS=0x09, rx_ready=0. The next valid frame 0x55 is received correctly.
- Assert rst mid-TX frame and mid-RX frame → tx=1 immediately; STATUS=0x01 after reset; no spurious byte is received afterwards. A 3-cycle low glitch on rx produces no byte.
